// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - Fetch and data-memory handshake bundle for the multicycle controller
interface multicycle_control_if #(
    parameter int N = 32
);
    logic [N-1:0] instr;
    logic         instr_valid;
    logic         instr_ready;
    logic         mem_req;
    logic         mem_ready;

    modport master (
        input  instr,
        input  instr_valid,
        input  mem_ready,
        output instr_ready,
        output mem_req
    );

    modport slave (
        output instr,
        output instr_valid,
        output mem_ready,
        input  instr_ready,
        input  mem_req
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Multicycle RV32I control FSM with fetch/memory handshakes and fault reporting
module multicycle_control #(
    parameter int N           = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus,
    input  logic                 BrEq,
    input  logic                 BrLT,
    output logic                 RegWEn,
    output logic [2:0]           ImmSel,
    output logic                 ALUsrc1,
    output logic                 ALUsrc2,
    output logic [3:0]           AluSEL,
    output logic                 BrUn,
    output logic                 MemRw,
    output logic [2:0]           ldU,
    output logic [1:0]           WBSel,
    output logic                 PCSel,
    output logic                 PCWEn,
    output logic [1:0]           fault
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int              CW       = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    typedef struct packed {
        logic [2:0] imm_sel;
        logic       src1;
        logic       src2;
        logic [3:0] alu_sel;
        logic       br_un;
        logic [2:0] ld_u;
        logic [1:0] wb_sel;
    } ctrl_t;

    state_t        state;
    ctrl_t         fields_q;
    ctrl_t         dec;
    logic [N-1:0]  instr_q;
    logic [CW-1:0] cnt;
    logic          mem_req_q;
    logic [2:0]    f3_in;

    // Datapath selects are decoded from the incoming word so they are already valid in DECODE.
    always_comb begin
        dec   = '0;
        f3_in = bus.instr[14:12];
        case (bus.instr[6:0])
            OP_R:      begin dec.alu_sel = {bus.instr[30], f3_in}; dec.wb_sel = 2'b01; end
            OP_IMM:    begin
                dec.src2    = 1'b1;
                dec.alu_sel = (f3_in == 3'b101) ? {bus.instr[30], f3_in} : {1'b0, f3_in};
                dec.wb_sel  = 2'b01;
            end
            OP_LOAD:   begin dec.src2 = 1'b1; dec.ld_u = f3_in; end
            OP_STORE:  begin dec.imm_sel = 3'b001; dec.src2 = 1'b1; end
            OP_BRANCH: begin
                dec.imm_sel = 3'b010; dec.src1 = 1'b1; dec.src2 = 1'b1; dec.br_un = f3_in[1];
            end
            OP_JAL:    begin dec.imm_sel = 3'b100; dec.src1 = 1'b1; dec.src2 = 1'b1; dec.wb_sel = 2'b10; end
            OP_JALR:   begin dec.src2 = 1'b1; dec.wb_sel = 2'b10; end
            OP_LUI:    begin dec.imm_sel = 3'b011; dec.src2 = 1'b1; dec.alu_sel = 4'b1111; dec.wb_sel = 2'b01; end
            OP_AUIPC:  begin dec.imm_sel = 3'b011; dec.src1 = 1'b1; dec.src2 = 1'b1; dec.wb_sel = 2'b01; end
            default:   ;
        endcase
    end

    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic       is_load_q, is_store_q, is_branch_q, is_jump_q, known_q, legal_q, writes_rd_q;
    logic       taken;
    logic       unused_instr_bits;

    assign op_q        = instr_q[6:0];
    assign f3_q        = instr_q[14:12];
    assign is_load_q   = (op_q == OP_LOAD);
    assign is_store_q  = (op_q == OP_STORE);
    assign is_branch_q = (op_q == OP_BRANCH);
    assign is_jump_q   = (op_q == OP_JAL) || (op_q == OP_JALR);
    assign writes_rd_q = (op_q == OP_R) || (op_q == OP_IMM) || is_load_q || is_jump_q
                      || (op_q == OP_LUI) || (op_q == OP_AUIPC);
    assign known_q     = writes_rd_q || is_store_q || is_branch_q;
    assign legal_q     = known_q && !(is_branch_q && (f3_q[2:1] == 2'b01));
    assign unused_instr_bits = ^{instr_q[N-1:15], instr_q[11:7]};

    always_comb begin
        taken = 1'b0;
        case (f3_q)
            3'b000:          taken = BrEq;
            3'b001:          taken = !BrEq;
            3'b100, 3'b110:  taken = BrLT;
            3'b101, 3'b111:  taken = !BrLT;
            default:         taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            fields_q  <= '0;
            instr_q   <= '0;
            cnt       <= '0;
            mem_req_q <= 1'b0;
            MemRw     <= 1'b0;
            RegWEn    <= 1'b0;
            PCWEn     <= 1'b0;
            PCSel     <= 1'b0;
            fault     <= 2'b00;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        instr_q  <= bus.instr;
                        fields_q <= dec;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!legal_q) begin
                        fields_q <= '0;
                        fault    <= 2'b01;
                        state    <= S_TRAP;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_load_q || is_store_q) begin
                        mem_req_q <= 1'b1;
                        MemRw     <= is_store_q;
                        cnt       <= '0;
                        state     <= S_MEM;
                    end else begin
                        RegWEn <= writes_rd_q;
                        PCWEn  <= 1'b1;
                        PCSel  <= is_jump_q || (is_branch_q && taken);
                        state  <= S_WB;
                    end
                end
                S_MEM: begin
                    // Completion wins over timeout when both land on the final wait cycle.
                    if (bus.mem_ready) begin
                        mem_req_q <= 1'b0;
                        MemRw     <= 1'b0;
                        RegWEn    <= is_load_q;
                        PCWEn     <= 1'b1;
                        state     <= S_WB;
                    end else if ((MEM_TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        mem_req_q <= 1'b0;
                        MemRw     <= 1'b0;
                        fields_q  <= '0;
                        fault     <= 2'b10;
                        state     <= S_TRAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WB: begin
                    fields_q <= '0;
                    RegWEn   <= 1'b0;
                    PCWEn    <= 1'b0;
                    PCSel    <= 1'b0;
                    cnt      <= '0;
                    state    <= S_FETCH;
                end
                default: ;
            endcase
        end
    end

    // Ready is held low while reset is asserted and rises as soon as reset releases.
    assign bus.instr_ready = rst_n && (state == S_FETCH);
    assign bus.mem_req     = mem_req_q;

    assign ImmSel  = fields_q.imm_sel;
    assign ALUsrc1 = fields_q.src1;
    assign ALUsrc2 = fields_q.src2;
    assign AluSEL  = fields_q.alu_sel;
    assign BrUn    = fields_q.br_un;
    assign ldU     = fields_q.ld_u;
    assign WBSel   = fields_q.wb_sel;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - Self-checking bench for multicycle_control
module tb_multicycle_control;
    localparam int N   = 32;
    localparam int TMO = 15;

    localparam logic [31:0] W_ADD  = 32'h002081B3;
    localparam logic [31:0] W_BNE  = 32'h00209463;
    localparam logic [31:0] W_SW   = 32'h0020A223;
    localparam logic [31:0] W_LW   = 32'h0040A183;
    localparam logic [31:0] W_ILL  = 32'h0000007F;
    localparam logic [31:0] W_BBAD = 32'h0020A063;

    typedef enum {T_R, T_I, T_L, T_S, T_B, T_JAL, T_JALR, T_LUI, T_AUIPC, T_ILL} itype_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       BrEq, BrLT;
    logic       RegWEn, ALUsrc1, ALUsrc2, BrUn, MemRw, PCSel, PCWEn;
    logic [2:0] ImmSel, ldU;
    logic [3:0] AluSEL;
    logic [1:0] WBSel, fault;

    int compared   = 0;
    int mismatched = 0;

    multicycle_control_if #(.N(N)) bus ();

    multicycle_control #(.N(N), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .BrEq(BrEq), .BrLT(BrLT),
        .RegWEn(RegWEn), .ImmSel(ImmSel), .ALUsrc1(ALUsrc1), .ALUsrc2(ALUsrc2),
        .AluSEL(AluSEL), .BrUn(BrUn), .MemRw(MemRw), .ldU(ldU), .WBSel(WBSel),
        .PCSel(PCSel), .PCWEn(PCWEn), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic itype_t classify(input logic [31:0] w);
        case (w[6:0])
            7'h33:   return T_R;
            7'h13:   return T_I;
            7'h03:   return T_L;
            7'h23:   return T_S;
            7'h63:   return (w[14:13] == 2'b01) ? T_ILL : T_B;
            7'h6F:   return T_JAL;
            7'h67:   return T_JALR;
            7'h37:   return T_LUI;
            7'h17:   return T_AUIPC;
            default: return T_ILL;
        endcase
    endfunction

    // Expected {ImmSel, ALUsrc1, ALUsrc2, AluSEL, BrUn, ldU, WBSel} for a legal word.
    function automatic logic [14:0] exp_fields(input logic [31:0] w);
        itype_t     t  = classify(w);
        logic [2:0] f3 = w[14:12];
        logic [2:0] imm;
        logic       s1, s2, bu;
        logic [3:0] alu;
        logic [2:0] ld;
        logic [1:0] wb;
        imm = (t == T_S) ? 3'd1 : (t == T_B) ? 3'd2 : (t == T_LUI || t == T_AUIPC) ? 3'd3
            : (t == T_JAL) ? 3'd4 : 3'd0;
        s1  = (t == T_B || t == T_JAL || t == T_AUIPC);
        s2  = (t != T_R);
        if (t == T_R || (t == T_I && f3 == 3'd5)) alu = {w[30], f3};
        else if (t == T_I)                        alu = {1'b0, f3};
        else if (t == T_LUI)                      alu = 4'hF;
        else                                      alu = 4'h0;
        bu  = (t == T_B) ? f3[1] : 1'b0;
        ld  = (t == T_L) ? f3 : 3'd0;
        wb  = (t == T_JAL || t == T_JALR) ? 2'd2
            : (t == T_R || t == T_I || t == T_LUI || t == T_AUIPC) ? 2'd1 : 2'd0;
        return {imm, s1, s2, alu, bu, ld, wb};
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
        if (f3 == 3'd0) return eq;
        if (f3 == 3'd1) return !eq;
        return f3[0] ? !lt : lt;
    endfunction

    function automatic logic [14:0] obs_fields();
        return {ImmSel, ALUsrc1, ALUsrc2, AluSEL, BrUn, ldU, WBSel};
    endfunction

    function automatic logic [6:0] obs_strobes();
        return {fault, RegWEn, PCWEn, PCSel, MemRw, bus.mem_req};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", bus.instr_ready, 0);
        chk("rst_fields", obs_fields(), 0);
        chk("rst_strobes", obs_strobes(), 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", bus.instr_ready, 1);
    endtask

    task automatic chk_trap_hold(input logic [1:0] f);
        bus.instr       = W_ADD;
        bus.instr_valid = 1'b1;
        bus.mem_ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("trap_ready", bus.instr_ready, 0);
            chk("trap_hold", {obs_strobes(), obs_fields()}, {f, 5'b0, 15'b0});
        end
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
    endtask

    // Runs one instruction from FETCH, checking every cycle; wait_n is the MEM-cycle index of mem_ready.
    task automatic run_instr(input logic [31:0] w, input logic beq, input logic blt,
                             input int wait_n, output bit trapped);
        itype_t      t   = classify(w);
        logic [14:0] ef  = exp_fields(w);
        bit          mem = (t == T_L || t == T_S);
        logic        rw  = (t != T_S && t != T_B);
        logic        pcs = (t == T_JAL || t == T_JALR) || (t == T_B && branch_taken(w[14:12], beq, blt));
        trapped = 1'b0;
        chk("fetch_ready", bus.instr_ready, 1);
        chk("fetch_fields", obs_fields(), 0);
        chk("fetch_strobes", obs_strobes(), 0);
        bus.mem_ready   = 1'($urandom);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        step();
        bus.instr       = $urandom;
        bus.instr_valid = 1'($urandom);
        chk("decode_ready", bus.instr_ready, 0);
        if (t == T_ILL) begin
            step();
            chk("illegal_trap", {obs_strobes(), obs_fields()}, {2'b01, 5'b0, 15'b0});
            trapped = 1'b1;
            bus.instr_valid = 1'b0;
            return;
        end
        chk("decode_fields", obs_fields(), ef);
        chk("decode_strobes", obs_strobes(), 0);
        step();
        chk("exec_fields", obs_fields(), ef);
        chk("exec_strobes", obs_strobes(), 0);
        BrEq = beq;
        BrLT = blt;
        bus.mem_ready = 1'b0;
        step();
        BrEq = 1'($urandom);
        BrLT = 1'($urandom);
        if (mem) begin
            for (int k = 0; k < 64; k++) begin
                chk("mem_strobes", obs_strobes(), {2'b00, 3'b000, (t == T_S), 1'b1});
                chk("mem_fields", obs_fields(), ef);
                bus.mem_ready = (k == wait_n);
                step();
                if (k == wait_n) break;
                if (k == TMO - 1) begin
                    chk("timeout_trap", {obs_strobes(), obs_fields()}, {2'b10, 5'b0, 15'b0});
                    trapped = 1'b1;
                    bus.mem_ready   = 1'b0;
                    bus.instr_valid = 1'b0;
                    return;
                end
            end
            bus.mem_ready = 1'($urandom);
        end
        chk("wb_fields", obs_fields(), ef);
        chk("wb_strobes", obs_strobes(), {2'b00, rw, 1'b1, pcs, 2'b00});
        chk("wb_ready", bus.instr_ready, 0);
        step();
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr(input int sel);
        logic [31:0] w = $urandom;
        int          k;
        case (sel)
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: begin
                w[6:0]   = 7'h63;
                k        = $urandom_range(0, 5);
                w[14:12] = (k < 2) ? 3'(k) : 3'(k + 2);
            end
            5: w[6:0] = 7'h6F;
            6: w[6:0] = 7'h67;
            7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17;
            default: w[6:0] = 7'h0F;
        endcase
        return w;
    endfunction

    initial begin
        bit trapped;
        BrEq = 1'b0;
        BrLT = 1'b0;
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        do_reset();

        run_instr(W_ADD, 1'b0, 1'b0, 0, trapped);
        run_instr(W_BNE, 1'b0, 1'b0, 0, trapped);
        run_instr(W_BNE, 1'b1, 1'b0, 0, trapped);
        run_instr(W_SW, 1'b0, 1'b0, 3, trapped);
        run_instr(W_LW, 1'b0, 1'b0, 0, trapped);
        run_instr(W_SW, 1'b0, 1'b0, TMO - 1, trapped);

        run_instr(W_LW, 1'b0, 1'b0, 100, trapped);
        chk("lw_timeout_seen", trapped, 1);
        chk_trap_hold(2'b10);
        do_reset();

        run_instr(W_ILL, 1'b0, 1'b0, 0, trapped);
        chk_trap_hold(2'b01);
        do_reset();
        run_instr(W_BBAD, 1'b0, 1'b0, 0, trapped);
        do_reset();

        // Reset dropped between clock edges while a store waits in MEM.
        bus.instr       = W_SW;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        step();
        step();
        chk("mid_mem_req_1", bus.mem_req, 1);
        step();
        chk("mid_mem_req_2", bus.mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mem_req_drop", {bus.mem_req, MemRw}, 0);
        chk("async_fields", obs_fields(), 0);
        step();
        rst_n = 1'b1;
        #1;
        run_instr(W_ADD, 1'b0, 1'b1, 0, trapped);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] w = rand_instr($urandom_range(0, 9));
            int          wt = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
            run_instr(w, 1'($urandom), 1'($urandom), wt, trapped);
            if (trapped) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter N, default 32, instruction width; only bits [31:0] are decoded, N>=32.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum MEM-state wait cycles before fault; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port instr  input  N  instruction word, sampled when instr_valid & instr_ready.
REQ-006 SHALL have ports instr_valid input 1 and instr_ready output 1, the fetch handshake.
REQ-007 SHALL have ports BrEq, BrLT  input  1 each  comparator results, sampled in EXEC.
REQ-008 SHALL have port mem_ready  input  1  data-memory completion.
REQ-009 SHALL have port mem_req  output  1  data-memory request.
REQ-010 SHALL have outputs RegWEn 1, ImmSel 3, ALUsrc1 1, ALUsrc2 1, AluSEL 4, BrUn 1, MemRw 1, ldU 3, WBSel 2, PCSel 1, PCWEn 1.
REQ-011 SHALL have port fault  output  2  00 none, 01 illegal instruction, 10 memory timeout.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-013 FETCH: instr_ready=1; on instr_valid, SHALL latch instr and go to DECODE; otherwise stay in FETCH.
REQ-014 DECODE (1 cycle): unsupported opcode, or a branch with funct3 010/011, SHALL set fault=01 and go to TRAP; otherwise SHALL go to EXEC.
REQ-015 EXEC (1 cycle): load/store SHALL go to MEM; all other instructions SHALL go to WB.
REQ-016 MEM: mem_req=1 and MemRw=1 for a store; mem_ready SHALL go to WB on the next edge.
REQ-017 MEM: a cycle counter SHALL increment each waiting cycle; reaching MEM_TIMEOUT without mem_ready SHALL set fault=10 and go to TRAP.
REQ-018 WB (1 cycle): PCWEn=1; RegWEn=1 for R, I, load, JAL, JALR, LUI and AUIPC; SHALL then go to FETCH.
REQ-019 TRAP SHALL be absorbing until reset; all control outputs stay 0 and fault is held.
REQ-020 Latency SHALL be 4 cycles minimum per non-memory instruction and 5+wait cycles per load/store, with FETCH counted as 1 cycle.
REQ-021 ImmSel SHALL be I=000, S=001, B=010, U=011, J=100.
REQ-022 WBSel SHALL be 00 memory, 01 ALU, 10 PC+4 (JAL/JALR).
REQ-023 AluSEL SHALL be:
- {instr[30],funct3} for R-type and for OP-IMM with funct3 101;
- {0,funct3} for other OP-IMM;
- 1111 for LUI;
- 0000 otherwise.
REQ-024 ALUsrc1=1 (PC) SHALL apply for branch, JAL and AUIPC; ALUsrc2=1 (immediate) SHALL apply for every non-R instruction.
REQ-025 ldU SHALL equal funct3 for loads and 000 otherwise.
REQ-026 BrUn SHALL equal funct3[1] for branches and 0 otherwise.
REQ-027 Branch taken conditions SHALL be:
- 000: BrEq; 001: !BrEq;
- 100/110: BrLT; 101/111: !BrLT.
The result SHALL be registered at the end of EXEC.
REQ-028 PCSel SHALL be 1 in WB for a taken branch, JAL and JALR, and 0 otherwise.
REQ-029 Decoded fields SHALL be held constant DECODE through WB; they SHALL be 0 in FETCH.
REQ-030 instr_valid outside FETCH and mem_ready outside MEM SHALL be ignored.
REQ-031 mem_ready asserted in the first MEM cycle SHALL complete with zero wait.

Reset
REQ-032 rst_n low SHALL immediately force: state FETCH, all outputs 0 (instr_ready 1 once released), latched instr 0, counter 0, fault 00.
REQ-033 Reset asserted mid-MEM SHALL drop mem_req in the same cycle without waiting for a clock edge.

Verification
REQ-034 Bench SHALL cover these scenarios:
- ADD 0x002081B3 -> DECODE/EXEC/WB; RegWEn=1 and AluSEL=0000 in WB only; PCSel=0.
- BNE funct3 001 with BrEq=0 in EXEC -> PCSel=1 and PCWEn=1 in WB; repeated with BrEq=1 -> PCSel=0.
- SW with mem_ready low 3 cycles -> mem_req=1 and MemRw=1 for 4 cycles, then WB with RegWEn=0.
- LW with mem_ready never asserted, MEM_TIMEOUT=15 -> TRAP after 15 MEM cycles, fault=10, mem_req=0.
- Opcode 0x7F -> TRAP; fault=01; instr_valid then ignored; rst_n pulse -> FETCH, fault=00.
- rst_n low during MEM -> mem_req 0 asynchronously; next instruction runs normally.
